// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared state encoding, index-width helper and default sizes for wide_add_sequencer.
package wide_add_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int N_DEF = 8;
    localparam int WORDS_DEF = 4;
    function automatic int idx_w(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction
endpackage

// File: rtl/n_bit_adder.sv
// n_bit_adder: combinational n-bit ripple adder with carry in/out.
module n_bit_adder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: adds two WORDS*N-bit operands one N-bit chunk per clock, LS chunk first.
// Define WIDE_ADD_SUB_EN to add a 'sub' port selecting a-b.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int WORDS = WORDS_DEF,
    localparam int W = N * WORDS,
    localparam int IW = idx_w(WORDS)
) (
    input  logic         clk,
    input  logic         rst,
`ifdef WIDE_ADD_SUB_EN
    input  logic         sub,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         busy
);
    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [W-1:0]   a_q, b_q, sum_q;
    logic           carry_q, cout_q;
    logic [N-1:0]   chunk_sum;
    logic           chunk_cout;
    logic           last;
    logic [W-1:0]   b_in;
    logic           c_in;

`ifdef WIDE_ADD_SUB_EN
    // Subtraction is a + ~b + 1; inverting at latch time is equivalent to per-chunk inversion.
    assign b_in = sub ? ~b : b;
    assign c_in = sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign last      = idx_q == IW'(WORDS - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign sum       = sum_q;
    assign carry_out = cout_q;

    n_bit_adder #(.n(N)) u_adder (
        .a   (a_q[int'(idx_q)*N +: N]),
        .b   (b_q[int'(idx_q)*N +: N]),
        .cin (carry_q),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = in_valid ? RUN : IDLE;
        else if (state_q == RUN)
            state_d = last ? DONE : RUN;
        else
            state_d = out_ready ? IDLE : DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && in_valid) begin
                a_q     <= a;
                b_q     <= b_in;
                carry_q <= c_in;
                idx_q   <= '0;
            end
            if (state_q == RUN) begin
                sum_q[int'(idx_q)*N +: N] <= chunk_sum;
                carry_q <= chunk_cout;
                idx_q   <= last ? '0 : idx_q + 1'b1;
                if (last) cout_q <= chunk_cout;
            end
        end
    end
endmodule
